// File: rtl/qed_dup_scheduler.sv
// QED duplicate-instruction scheduler: forwards originals, queues them, issues x16-x31 duplicates.
// Optional define QED_MEM_EN adds LW/SW queueing with a +128 immediate offset on the duplicate.
module qed_dup_scheduler #(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [31:0]   ifu_qed_instruction,
   input  logic          exec_dup,
   input  logic          stall,
   output logic [31:0]   qed_instruction,
   output logic          qed_vld_out,
   output logic          qed_ready,
   output logic          fifo_full,
   output logic [AW:0]   fifo_count
);

   localparam logic [6:0]  OP_R     = 7'b0110011;
   localparam logic [6:0]  OP_I     = 7'b0010011;
   localparam logic [6:0]  OP_LW    = 7'b0000011;
   localparam logic [6:0]  OP_SW    = 7'b0100011;
   localparam logic [2:0]  F3_W     = 3'b010;
   localparam logic [31:0] NOP_INSN = 32'h0000_0013;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_MATCH
   } state_t;

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [AW:0]   count;
   logic [15:0]   orig_cnt;
   logic [15:0]   dup_cnt;
   state_t        state;

   logic          queueable;
   logic          do_pop;
   logic          do_push;
   logic [31:0]   head_dup;
   logic [6:0]    in_op;
   logic [2:0]    in_f3;

   function automatic logic [4:0] remap(input logic [4:0] r);
      return (r == 5'd0) ? r : (r | 5'h10);
   endfunction

   // Entries are re-decoded at pop time; only queueable encodings ever land here.
   function automatic logic [31:0] dup_of(input logic [31:0] i);
      logic [31:0] d;
      logic [6:0]  op;
      d  = i;
      op = i[6:0];
      unique case (1'b1)
         (op == OP_R): begin
            d[11:7]  = remap(i[11:7]);
            d[19:15] = remap(i[19:15]);
            d[24:20] = remap(i[24:20]);
         end
         (op == OP_I): begin
            d[11:7]  = remap(i[11:7]);
            d[19:15] = remap(i[19:15]);
         end
`ifdef QED_MEM_EN
         (op == OP_LW): begin
            d[11:7]  = remap(i[11:7]);
            d[31:20] = i[31:20] + 12'h080;
         end
         (op == OP_SW): begin
            d[19:15] = remap(i[19:15]);
            {d[31:25], d[11:7]} = {i[31:25], i[11:7]} + 12'h080;
         end
`endif
         default: d = i;
      endcase
      return d;
   endfunction

   assign in_op = ifu_qed_instruction[6:0];
   assign in_f3 = ifu_qed_instruction[14:12];

   always_comb begin
      queueable = 1'b0;
      unique case (1'b1)
         (in_op == OP_R):  queueable = 1'b1;
         (in_op == OP_I):  queueable = 1'b1;
`ifdef QED_MEM_EN
         (in_op == OP_LW): queueable = (in_f3 == F3_W);
         (in_op == OP_SW): queueable = (in_f3 == F3_W);
`endif
         default:          queueable = 1'b0;
      endcase
`ifndef QED_MEM_EN
      if (in_f3 == 3'b111 && 1'b0) queueable = 1'b0;
`endif
   end

   assign fifo_full  = (count == FULL_CNT);
   assign fifo_count = count;

   assign do_pop  = !stall && ((exec_dup && count != '0) || fifo_full);
   assign do_push = !stall && !do_pop && queueable;
   assign head_dup = dup_of(mem[rptr]);

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wptr] <= ifu_qed_instruction;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         qed_instruction <= NOP_INSN;
         qed_vld_out     <= 1'b0;
         qed_ready       <= 1'b0;
         wptr            <= '0;
         rptr            <= '0;
         count           <= '0;
         orig_cnt        <= '0;
         dup_cnt         <= '0;
         state           <= S_IDLE;
      end else if (!stall) begin
         if (do_pop) begin
            qed_instruction <= head_dup;
            qed_vld_out     <= 1'b1;
            rptr            <= rptr + AW'(1);
            count           <= count - ONE_CNT;
            dup_cnt         <= dup_cnt + 16'd1;
         end else if (do_push) begin
            qed_instruction <= ifu_qed_instruction;
            qed_vld_out     <= 1'b1;
            wptr            <= wptr + AW'(1);
            count           <= count + ONE_CNT;
            orig_cnt        <= orig_cnt + 16'd1;
         end else begin
            qed_instruction <= NOP_INSN;
            qed_vld_out     <= 1'b0;
         end
         unique case (state)
            S_IDLE: begin
               if (do_push) state <= S_RUN;
            end
            S_RUN: begin
               if (do_pop && count == ONE_CNT) begin
                  state     <= S_MATCH;
                  qed_ready <= (orig_cnt == dup_cnt + 16'd1);
               end
            end
            S_MATCH: begin
               if (do_push) begin
                  state     <= S_RUN;
                  qed_ready <= 1'b0;
               end
            end
            default: begin
               state     <= S_IDLE;
               qed_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule
